bip_control_unit: RTL and testbench
===================================

// Module: bip_control_unit
// PURPOSE
//  Sequencer/decoder directly upstream of the BIP datapath.
//  Fetches 16-bit instructions from program memory, decodes them, and drives the datapath
//  controls SelA, SelB, WrAcc, Op and inst_operand, plus data-memory WrRam/RdRam.
//  Multi-cycle: FETCH + EXEC = 2 clocks per instruction. Stops on HLT and raises done.
// PARAMETERS
//  len_data   16  instruction / data word width
//  len_addr   11  operand width = program counter width
//  len_opcode 5   opcode field width; len_opcode + len_addr == len_data
//  len_mux_a  2   SelA width
//  len_cycles 32  cycle-counter width
// PORTS
//  clk           in   1           system clock, rising edge
//  reset         in   1           asynchronous, active-low reset
//  start         in   1           1-cycle pulse: begin/restart program at PC=0
//  Pm_Data       in   len_data    program memory read data (registered ROM, 1-cycle latency)
//  Pm_Addr       out  len_addr    program memory address (= PC)
//  Pm_Rd         out  1           program memory read enable
//  SelA          out  len_mux_a   00=data_mem_out, 01=inst_operand, 10=alu_result
//  SelB          out  1           0=data_mem_out, 1=inst_operand
//  WrAcc         out  1           accumulator write enable
//  Op            out  1           0=add, 1=sub
//  WrRam         out  1           data memory write (STO)
//  RdRam         out  1           data memory read (LD/ADD/SUB); combinational-read RAM
//  inst_operand  out  len_addr    Pm_Data[len_addr-1:0]
//  done          out  1           1 while in HALT
//  illegal       out  1           sticky illegal-opcode flag (BIP_ILLEGAL_TRAP_EN only, else 0)
//  cycle_count   out  len_cycles  clocks spent in FETCH+EXEC since last start
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, PC=0, cycle_count=0, done=0, illegal=0;
//   all control outputs 0; Pm_Addr=0.
//  FSM: IDLE -start-> FETCH -> EXEC -> (HLT ? HALT : FETCH); HALT -start-> FETCH.
//  FETCH: Pm_Addr=PC, Pm_Rd=1, all datapath/RAM controls 0.
//  EXEC: Pm_Data valid. Decode opcode=Pm_Data[15:11]. Controls asserted for this one cycle only.
//   PC<=PC+1 at end of EXEC unless HLT.
//  Decode table (op: WrAcc SelA SelB Op WrRam RdRam):
//   00000 HLT  : 0 -  - - 0 0  -> HALT, PC frozen
//   00001 STO  : 0 -  - - 1 0
//   00010 LD   : 1 00 - - 0 1
//   00011 LDI  : 1 01 - - 0 0
//   00100 ADD  : 1 10 0 0 0 1
//   00101 ADDI : 1 10 1 0 0 0
//   00110 SUB  : 1 10 0 1 0 1
//   00111 SUBI : 1 10 1 1 0 0
//   Don't-care fields are driven 0.
//  Opcodes 01000..11111 are illegal (see CONFIGURATION).
//  PC wraps 2^len_addr-1 -> 0 with no flag.
//  cycle_count +1 every clock in FETCH/EXEC; holds in IDLE/HALT; wraps silently.
//  start: honoured only in IDLE/HALT. In HALT: PC=0, cycle_count=0, done=0, illegal=0,
//   then FETCH next clock. Ignored in FETCH/EXEC.
//  done=1 from the clock after HLT's EXEC until start or reset.
//  Reset mid-instruction: immediate return to IDLE; the in-flight WrAcc/WrRam is dropped.
// CONFIGURATION
//  BIP_ILLEGAL_TRAP_EN defined: illegal opcode in EXEC -> no controls asserted, illegal<=1,
//   PC frozen, state HALT (done=1).
//  Undefined: illegal opcode executes as NOP (no controls, PC+1, continue); illegal tied to 0.
// TESTING
//  reset low mid-EXEC of ADDI -> all outputs 0 immediately; PC=0, state IDLE.
//  prog LDI 5; ADDI 3; STO 7; HLT, start -> EXEC1 SelA=01 WrAcc=1 operand=5;
//   EXEC3 WrRam=1 operand=7; done=1 at clk 8; cycle_count=8.
//  LD 2; SUB 3 -> LD: SelA=00 RdRam=1; SUB: SelA=10 SelB=0 Op=1 RdRam=1 WrAcc=1.
//  start pulsed during FETCH/EXEC -> ignored, sequence unchanged; start in HALT -> PC=0, rerun.
//  len_addr=3, 8 ADDI, no HLT -> Pm_Addr 7 then 0, run continues.
//  opcode 01010 at PC=1: with BIP_ILLEGAL_TRAP_EN -> illegal=1, done=1, Pm_Addr stays 1;
//   without -> no controls, Pm_Addr=2 next FETCH.

Source files
------------

// File: rtl/bip_control_unit.sv
// BIP sequencer/decoder: two-clock FETCH/EXEC instruction cycle driving datapath and data-RAM controls.
// Optional feature macro: BIP_ILLEGAL_TRAP_EN (illegal opcode halts and sets sticky illegal flag).
module bip_control_unit #(
  parameter int unsigned len_data   = 16,
  parameter int unsigned len_addr   = 11,
  parameter int unsigned len_opcode = 5,
  parameter int unsigned len_mux_a  = 2,
  parameter int unsigned len_cycles = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [len_data-1:0]   Pm_Data,
  output logic [len_addr-1:0]   Pm_Addr,
  output logic                  Pm_Rd,
  output logic [len_mux_a-1:0]  SelA,
  output logic                  SelB,
  output logic                  WrAcc,
  output logic                  Op,
  output logic                  WrRam,
  output logic                  RdRam,
  output logic [len_addr-1:0]   inst_operand,
  output logic                  done,
  output logic                  illegal,
  output logic [len_cycles-1:0] cycle_count
);

  localparam logic [len_opcode-1:0] op_hlt  = len_opcode'(0);
  localparam logic [len_opcode-1:0] op_sto  = len_opcode'(1);
  localparam logic [len_opcode-1:0] op_ld   = len_opcode'(2);
  localparam logic [len_opcode-1:0] op_ldi  = len_opcode'(3);
  localparam logic [len_opcode-1:0] op_add  = len_opcode'(4);
  localparam logic [len_opcode-1:0] op_addi = len_opcode'(5);
  localparam logic [len_opcode-1:0] op_sub  = len_opcode'(6);
  localparam logic [len_opcode-1:0] op_subi = len_opcode'(7);

  localparam logic [len_mux_a-1:0] sel_mem = len_mux_a'(0);
  localparam logic [len_mux_a-1:0] sel_imm = len_mux_a'(1);
  localparam logic [len_mux_a-1:0] sel_alu = len_mux_a'(2);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_fetch = 2'd1,
    st_exec  = 2'd2,
    st_halt  = 2'd3
  } state_t;

  state_t                state;
  logic [len_addr-1:0]   pc;
  logic [len_cycles-1:0] cycles;
  logic                  done_q;
  logic [len_opcode-1:0] opcode;
  logic                  is_exec;

  assign opcode  = Pm_Data[len_data-1 -: len_opcode];
  assign is_exec = (state == st_exec);

`ifdef BIP_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic opcode_illegal;
  assign opcode_illegal = (opcode > op_subi);
  assign illegal        = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Sequencer: state, program counter, cycle counter and halt status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= st_idle;
      pc        <= '0;
      cycles    <= '0;
      done_q    <= 1'b0;
`ifdef BIP_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        st_idle: begin
          if (start) begin
            state  <= st_fetch;
            pc     <= '0;
            cycles <= '0;
          end
        end
        st_fetch: begin
          state  <= st_exec;
          cycles <= cycles + len_cycles'(1);
        end
        st_exec: begin
          cycles <= cycles + len_cycles'(1);
          if (opcode == op_hlt) begin
            state  <= st_halt;
            done_q <= 1'b1;
          end
`ifdef BIP_ILLEGAL_TRAP_EN
          else if (opcode_illegal) begin
            state     <= st_halt;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end
`endif
          else begin
            state <= st_fetch;
            pc    <= pc + len_addr'(1);
          end
        end
        st_halt: begin
          if (start) begin
            state     <= st_fetch;
            pc        <= '0;
            cycles    <= '0;
            done_q    <= 1'b0;
`ifdef BIP_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign Pm_Addr      = pc;
  assign Pm_Rd        = (state == st_fetch);
  assign done         = done_q;
  assign cycle_count  = cycles;
  assign inst_operand = is_exec ? Pm_Data[len_addr-1:0] : '0;

  // Decode is gated by EXEC: ROM data is only valid in that cycle, so controls follow it directly.
  always_comb begin
    SelA  = '0;
    SelB  = 1'b0;
    WrAcc = 1'b0;
    Op    = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (is_exec) begin
      case (opcode)
        op_sto: WrRam = 1'b1;
        op_ld: begin
          WrAcc = 1'b1;
          SelA  = sel_mem;
          RdRam = 1'b1;
        end
        op_ldi: begin
          WrAcc = 1'b1;
          SelA  = sel_imm;
        end
        op_add: begin
          WrAcc = 1'b1;
          SelA  = sel_alu;
          RdRam = 1'b1;
        end
        op_addi: begin
          WrAcc = 1'b1;
          SelA  = sel_alu;
          SelB  = 1'b1;
        end
        op_sub: begin
          WrAcc = 1'b1;
          SelA  = sel_alu;
          Op    = 1'b1;
          RdRam = 1'b1;
        end
        op_subi: begin
          WrAcc = 1'b1;
          SelA  = sel_alu;
          SelB  = 1'b1;
          Op    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: a per-cycle scoreboard of expected outputs, checked at negedge.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] Pm_Data = '0;
  logic [10:0] Pm_Addr;
  logic        Pm_Rd;
  logic [1:0]  SelA;
  logic        SelB, WrAcc, Op, WrRam, RdRam;
  logic [10:0] inst_operand;
  logic        done, illegal;
  logic [31:0] cycle_count;

  bip_control_unit dut (
    .clk(clk), .reset(reset), .start(start), .Pm_Data(Pm_Data),
    .Pm_Addr(Pm_Addr), .Pm_Rd(Pm_Rd), .SelA(SelA), .SelB(SelB),
    .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam),
    .inst_operand(inst_operand), .done(done), .illegal(illegal),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Registered program ROM, one-cycle read latency.
  logic [15:0] rom [2048];
  always @(posedge clk) if (Pm_Rd) Pm_Data <= rom[Pm_Addr];

  typedef struct packed {
    logic [10:0] addr;
    logic        rd;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        wr_ram;
    logic        rd_ram;
    logic [10:0] operand;
    logic        done;
  } row_t;

  row_t q[$];
  int checks = 0;
  int failures = 0;
`ifdef BIP_ILLEGAL_TRAP_EN
  localparam bit trap = 1'b1;
`else
  localparam bit trap = 1'b0;
`endif

  function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] arg);
    return {opc, arg};
  endfunction

  function automatic row_t sample();
    row_t r;
    r = '{addr: Pm_Addr, rd: Pm_Rd, sel_a: SelA, sel_b: SelB, wr_acc: WrAcc, op: Op,
          wr_ram: WrRam, rd_ram: RdRam, operand: inst_operand, done: done};
    return r;
  endfunction

  // Expected FETCH and EXEC rows for one instruction, from the ISA decode table.
  task automatic push_instr(input logic [10:0] addr, input logic [15:0] instr);
    row_t r;
    r = '0; r.addr = addr; r.rd = 1'b1;
    q.push_back(r);
    r = '0; r.addr = addr; r.operand = instr[10:0];
    case (instr[15:11])
      5'd1: r.wr_ram = 1'b1;
      5'd2: begin r.wr_acc = 1'b1; r.sel_a = 2'b00; r.rd_ram = 1'b1; end
      5'd3: begin r.wr_acc = 1'b1; r.sel_a = 2'b01; end
      5'd4: begin r.wr_acc = 1'b1; r.sel_a = 2'b10; r.rd_ram = 1'b1; end
      5'd5: begin r.wr_acc = 1'b1; r.sel_a = 2'b10; r.sel_b = 1'b1; end
      5'd6: begin r.wr_acc = 1'b1; r.sel_a = 2'b10; r.op = 1'b1; r.rd_ram = 1'b1; end
      5'd7: begin r.wr_acc = 1'b1; r.sel_a = 2'b10; r.sel_b = 1'b1; r.op = 1'b1; end
      default: ;
    endcase
    q.push_back(r);
  endtask

  task automatic push_halt(input logic [10:0] addr, input int n);
    row_t r;
    r = '0; r.addr = addr; r.done = 1'b1;
    for (int i = 0; i < n; i++) q.push_back(r);
  endtask

  task automatic push_zero();
    row_t r;
    r = '0;
    q.push_back(r);
  endtask

  task automatic cmp_row(input string tag);
    row_t a, e;
    a = sample();
    checks++;
    if (q.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, a);
    end else begin
      e = q.pop_front();
      assert (a === e) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, a, e);
      end
    end
  endtask

  task automatic cmp_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every queued row, one per clock; start is pulsed after rows flagged in mask.
  task automatic check_rows(input string tag, input logic [31:0] mask);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      cmp_row(tag);
      start = mask[i];
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_rom(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) rom[i] = fill;
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    start = 1'b0;
    clear_rom(16'h0000);
    repeat (2) @(negedge clk);

    push_zero();
    cmp_row("reset_outputs");
    cmp_val("reset_cycles", cycle_count, 0);
    cmp_val("reset_illegal", 32'(illegal), 0);
    reset = 1'b1;
    @(negedge clk);
    push_zero();
    cmp_row("idle_hold");

    // LDI 5; ADDI 3; STO 7; HLT
    rom[0] = ins(5'd3, 11'd5);
    rom[1] = ins(5'd5, 11'd3);
    rom[2] = ins(5'd1, 11'd7);
    rom[3] = ins(5'd0, 11'd0);
    for (int i = 0; i < 4; i++) push_instr(11'(i), rom[i]);
    push_halt(11'd3, 2);
    pulse_start();
    check_rows("prog_a", 32'd0);
    cmp_val("prog_a_cycles", cycle_count, 8);

    // Restart from HALT with start pulses during EXEC and FETCH, which must be ignored
    for (int i = 0; i < 4; i++) push_instr(11'(i), rom[i]);
    push_halt(11'd3, 2);
    pulse_start();
    check_rows("rerun", 32'b0110);
    cmp_val("rerun_cycles", cycle_count, 8);

    // LD 2; SUB 3; HLT
    rom[0] = ins(5'd2, 11'd2);
    rom[1] = ins(5'd6, 11'd3);
    rom[2] = ins(5'd0, 11'd0);
    for (int i = 0; i < 3; i++) push_instr(11'(i), rom[i]);
    push_halt(11'd2, 1);
    pulse_start();
    check_rows("ld_sub", 32'd0);
    cmp_val("ld_sub_cycles", cycle_count, 6);

    // Illegal opcode 01010 at PC=1
    rom[0] = ins(5'd5, 11'd1);
    rom[1] = ins(5'b01010, 11'h015);
    rom[2] = ins(5'd3, 11'd4);
    rom[3] = ins(5'd0, 11'd0);
    push_instr(11'd0, rom[0]);
    push_instr(11'd1, rom[1]);
    if (trap) begin
      push_halt(11'd1, 2);
    end else begin
      push_instr(11'd2, rom[2]);
      push_instr(11'd3, rom[3]);
      push_halt(11'd3, 1);
    end
    pulse_start();
    check_rows("illegal_op", 32'd0);
    cmp_val("illegal_flag", 32'(illegal), 32'(trap));

    // Asynchronous reset in the EXEC cycle of ADDI
    rom[0] = ins(5'd5, 11'd9);
    push_instr(11'd0, rom[0]);
    pulse_start();
    cmp_row("rst_fetch");
    cmp_val("illegal_cleared", 32'(illegal), 0);
    @(negedge clk);
    cmp_row("rst_exec");
    reset = 1'b0;
    #1;
    push_zero();
    cmp_row("rst_async");
    cmp_val("rst_cycles", cycle_count, 0);
    @(negedge clk);
    push_zero();
    cmp_row("rst_idle");
    reset = 1'b1;
    @(negedge clk);

    // PC wrap: ADDI everywhere, no HLT
    clear_rom(ins(5'd5, 11'd1));
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (Pm_Rd === 1'b1 && Pm_Addr === 11'd2047) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL wrap_timeout: observed Pm_Addr=%0d expected 2047 within 5000 clocks", Pm_Addr);
    end else begin
      cmp_val("wrap_cycles_top", cycle_count, 4094);
      repeat (2) @(negedge clk);
      cmp_val("wrap_addr", 32'(Pm_Addr), 0);
      cmp_val("wrap_rd", 32'(Pm_Rd), 1);
      cmp_val("wrap_cycles", cycle_count, 4096);
      cmp_val("wrap_done", 32'(done), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
